des_key_load_ctrl: RTL
======================

// Module: des_key_load_ctrl
// PURPOSE
//   Sequences loading of 64-bit DES keys into the key-whitening datapath and on to the DES core.
//   Arbitrates between two key requesters (host port 0, debug/test port 1) using round-robin.
//   Captures the granted key and runs it through a registered XOR-mask stage.
//   Presents the masked key to the DES core with a valid/ready handshake.
//   Sits between the key sources and the DES core's key-schedule input.
// PARAMETERS
//   KEY_MASK  64'hD5A0C370B049996E  whitening constant XORed into every granted key
//   MASK_LAT  2                     cycles spent in MASK state; legal range 1..15
// PORTS
//   CLK        in   1        single clock; all state is updated on the rising edge
//   RESET      in   1        asynchronous, active-high
//   REQ0       in   1        requester 0 key-load request (level)
//   KEY0       in   [64:1]   requester 0 key, sampled at grant
//   REQ1       in   1        requester 1 key-load request (level)
//   KEY1       in   [64:1]   requester 1 key, sampled at grant
//   ACK0       out  1        one-cycle pulse: requester 0 key captured
//   ACK1       out  1        one-cycle pulse: requester 1 key captured
//   BUSY       out  1        high in any state other than IDLE
//   KEY_OUT    out  [63:0]   masked key to DES core; KEY_OUT[i-1] = KEY[i] ^ KEY_MASK[i-1]
//   KEY_VALID  out  1        KEY_OUT is valid, held until accepted
//   KEY_READY  in   1        DES core accepts KEY_OUT when KEY_VALID && KEY_READY
//   KEY_SRC    out  1        requester index whose key is in KEY_OUT
// BEHAVIOUR
//   Reset values: all outputs 0; key register 0; mask register 0; RR pointer 0; state IDLE.
//   States: IDLE, MASK, PRESENT.
//   IDLE:
//     - if REQ0 or REQ1 is high at an edge: grant, capture the key, pulse ACKn, go to MASK,
//       load cnt = MASK_LAT-1.
//     - both requests high: grant the requester selected by the RR pointer.
//     - after any grant, the pointer points to the other requester.
//   MASK:
//     - mask register <= key_reg ^ KEY_MASK on the first edge.
//     - cnt decrements every edge; when cnt==0, go to PRESENT.
//   PRESENT:
//     - KEY_VALID=1 and KEY_OUT/KEY_SRC held stable until the handshake.
//     - on the edge with KEY_READY=1: return to IDLE, KEY_VALID=0.
//   Latency: KEY_VALID rises MASK_LAT edges after the capture edge.
//     Minimum request-to-request throughput is MASK_LAT+2 cycles.
//   Requests are ignored outside IDLE; no queueing.
//     A requester holding REQ is served on the next IDLE sample.
//     A request dropped before it is sampled is lost silently.
//   KEY_READY already high when KEY_VALID rises: transfer completes after exactly one valid cycle.
//   KEY_READY toggling while KEY_VALID is low has no effect.
//   ACK is a single pulse even if REQ stays high; the next grant needs the next IDLE sample.
//   RESET mid-operation: immediate return to IDLE, outputs and registers cleared.
//     The in-flight key is discarded and no ACK or valid is produced.
//   Bit mapping is fixed: input [64:1] maps onto output [63:0], one bit down, no reordering.
// STRUCTURE
//   Package des_key_pkg:
//     - KEY_W=64
//     - default KEY_MASK constant
//     - state encoding {IDLE=2'd0, MASK=2'd1, PRESENT=2'd2}
//   Sub-module key_mask_stage:
//     - registered XOR of a [64:1] key with KEY_MASK to [63:0]
//     - load enable, async active-high reset
//   Top level: RR arbiter, FSM, latency counter, key capture register.
// TESTING
//   1. REQ0, KEY0=0, KEY_READY=1, MASK_LAT=2 -> ACK0 pulse; KEY_VALID 2 edges later;
//      KEY_OUT=D5A0C370B049996E; KEY_SRC=0.
//   2. REQ1, KEY1=FFFF_FFFF_FFFF_FFFF -> KEY_OUT=2A5F3C8F4FB66691; KEY_SRC=1; ACK0 stays 0.
//   3. REQ0 and REQ1 held high together for 3 loads -> grants alternate 0,1,0.
//      Each ACK is exactly one cycle wide.
//   4. KEY_READY low for 5 cycles in PRESENT -> KEY_VALID and KEY_OUT stable throughout.
//      Single transfer; BUSY falls one cycle after KEY_READY rises.
//   5. RESET asserted in MASK -> all outputs 0 asynchronously, state IDLE.
//      After release, a new REQ0 is served normally.
//   6. REQ1 pulsed only while BUSY -> never granted; ACK1 stays 0.

Source files
------------

// File: rtl/des_key_pkg.sv
// Shared definitions for the DES key-load controller: widths, default whitening
// constant, FSM encoding and the round-robin pick helper.
package des_key_pkg;

    localparam int unsigned KEY_W = 64;
    localparam int unsigned CNT_W = 4;

    localparam logic [KEY_W-1:0] DEFAULT_KEY_MASK = 64'hD5A0C370B049996E;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MASK    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    // Returns the requester index to grant; only meaningful when at least one request is high.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
        logic sel;
        if (req0 && req1) begin
            sel = ptr;
        end else if (req1) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/key_mask_stage.sv
// Registered XOR whitening stage: a [KEY_W:1] key in, a [KEY_W-1:0] masked key out.
// Bit i of the input lands on bit i-1 of the output; no reordering.
module key_mask_stage
    import des_key_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MASK = DEFAULT_KEY_MASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [KEY_W:1]   key_in,
    output logic [KEY_W-1:0] key_out
);

    logic [KEY_W-1:0] mask_d;
    logic [KEY_W-1:0] mask_q;

    always_comb begin
        mask_d = mask_q;
        if (load_en) begin
            mask_d = key_in ^ KEY_MASK;
        end else begin
            mask_d = mask_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= {KEY_W{1'b0}};
        end else begin
            mask_q <= mask_d;
        end
    end

    assign key_out = mask_q;

endmodule

// File: rtl/des_key_load_ctrl.sv
// DES key-load sequencer: round-robin arbitration of two key requesters, key capture,
// MASK_LAT-cycle whitening phase, then valid/ready presentation to the DES core.
module des_key_load_ctrl
    import des_key_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_MASK = DEFAULT_KEY_MASK,
    parameter int unsigned      MASK_LAT = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [KEY_W:1]   KEY0,
    input  logic             REQ1,
    input  logic [KEY_W:1]   KEY1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             BUSY,
    output logic [KEY_W-1:0] KEY_OUT,
    output logic             KEY_VALID,
    input  logic             KEY_READY,
    output logic             KEY_SRC
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MASK_LAT - 1);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             rr_d, rr_q;
    logic [KEY_W:1]   key_d, key_q;
    logic             src_d, src_q;
    logic             ack0_d, ack0_q;
    logic             ack1_d, ack1_q;
    logic             valid_d, valid_q;
    logic             busy_d, busy_q;
    logic             mask_load_s;
    logic             grant_vld_s;
    logic             grant_sel_s;

    assign grant_vld_s = REQ0 | REQ1;
    assign grant_sel_s = rr_pick(REQ0, REQ1, rr_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        key_d       = key_q;
        src_d       = src_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        valid_d     = valid_q;
        busy_d      = busy_q;
        mask_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    state_d = MASK;
                    cnt_d   = CNT_INIT;
                    key_d   = grant_sel_s ? KEY1 : KEY0;
                    src_d   = grant_sel_s;
                    ack0_d  = ~grant_sel_s;
                    ack1_d  = grant_sel_s;
                    rr_d    = ~grant_sel_s;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            MASK: begin
                // The counter starts at MASK_LAT-1, so this marks the first MASK edge.
                mask_load_s = (cnt_q == CNT_INIT);
                if (cnt_q == CNT_ZERO) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            PRESENT: begin
                if (KEY_READY) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            rr_q    <= 1'b0;
            key_q   <= {KEY_W{1'b0}};
            src_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            key_q   <= key_d;
            src_q   <= src_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    key_mask_stage #(
        .KEY_MASK (KEY_MASK)
    ) u_mask (
        .clk     (CLK),
        .rst     (RESET),
        .load_en (mask_load_s),
        .key_in  (key_q),
        .key_out (KEY_OUT)
    );

    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign BUSY      = busy_q;
    assign KEY_VALID = valid_q;
    assign KEY_SRC   = src_q;

endmodule
